// File: rtl/serial_width_adapter_if.sv
// Handshake bundle for serial_width_adapter: host->target word stream in,
// narrow beat stream out, narrow beat stream in, reassembled word stream out.
// Signals: host_in_*, narrow_out_* (host->target), narrow_in_*, host_out_* (target->host).
// Modports: slave = adapter side, master = environment (host + target) side.
interface serial_width_adapter_if #(
    parameter int WIDE_W   = 32,
    parameter int NARROW_W = 4
);
    logic                host_in_valid;
    logic                host_in_ready;
    logic [WIDE_W-1:0]   host_in_bits;

    logic                narrow_out_valid;
    logic                narrow_out_ready;
    logic [NARROW_W-1:0] narrow_out_bits;

    logic                narrow_in_valid;
    logic                narrow_in_ready;
    logic [NARROW_W-1:0] narrow_in_bits;

    logic                host_out_valid;
    logic                host_out_ready;
    logic [WIDE_W-1:0]   host_out_bits;

    modport slave (
        input  host_in_valid, host_in_bits, narrow_out_ready,
        input  narrow_in_valid, narrow_in_bits, host_out_ready,
        output host_in_ready, narrow_out_valid, narrow_out_bits,
        output narrow_in_ready, host_out_valid, host_out_bits
    );

    modport master (
        output host_in_valid, host_in_bits, narrow_out_ready,
        output narrow_in_valid, narrow_in_bits, host_out_ready,
        input  host_in_ready, narrow_out_valid, narrow_out_bits,
        input  narrow_in_ready, host_out_valid, host_out_bits
    );
endinterface

// File: rtl/serial_width_adapter.sv
// Purpose: splits WIDE_W host words into NARROW_W beats (LSB slice first) and
//          reassembles target beats into host words; directions are independent.
// Latency: host fire t -> first beat t+1; last target beat t -> host word valid t+1.
// Backpressure: one-word buffer per direction; narrow_out_ready low freezes the
//          serializer, host_out_ready low with a full word stalls narrow_in_ready.
// Ports: clock, reset (synchronous, active-high), bus (serial_width_adapter_if.slave).
// Optional: SERIAL_WIDTH_ADAPTER_STATS_EN adds tx_words / rx_words word counters.
module serial_width_adapter #(
    parameter int WIDE_W   = 32,
    parameter int NARROW_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    serial_width_adapter_if.slave bus
`ifdef SERIAL_WIDTH_ADAPTER_STATS_EN
    ,
    output logic [31:0]           tx_words,
    output logic [31:0]           rx_words
`endif
);
    localparam int RATIO = WIDE_W / NARROW_W;
    localparam int IDX_W = $clog2(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    // Serializer state
    logic              tx_busy_q, tx_busy_d;
    logic [WIDE_W-1:0] tx_buf_q,  tx_buf_d;
    logic [IDX_W-1:0]  tx_idx_q,  tx_idx_d;

    // Deserializer state
    logic              rx_full_q, rx_full_d;
    logic [WIDE_W-1:0] rx_buf_q,  rx_buf_d;
    logic [IDX_W-1:0]  rx_idx_q,  rx_idx_d;

    logic host_in_fire, narrow_out_fire, tx_last;
    logic narrow_in_fire, host_out_fire, rx_last;

    assign tx_last = (tx_idx_q == LAST_IDX);
    assign rx_last = (rx_idx_q == LAST_IDX);

    // The buffer can take a new word while its last beat leaves, giving a
    // gapless stream across word boundaries.
    assign bus.host_in_ready    = !reset && (!tx_busy_q || (tx_last && bus.narrow_out_ready));
    assign bus.narrow_out_valid = tx_busy_q;
    assign bus.narrow_out_bits  = tx_buf_q[int'(tx_idx_q) * NARROW_W +: NARROW_W];

    // A beat may land while the held word drains in the same cycle; the slice
    // it overwrites has already been consumed by the host.
    assign bus.narrow_in_ready  = !reset && (!rx_full_q || bus.host_out_ready);
    assign bus.host_out_valid   = rx_full_q;
    assign bus.host_out_bits    = rx_buf_q;

    assign host_in_fire    = bus.host_in_valid    && bus.host_in_ready;
    assign narrow_out_fire = bus.narrow_out_valid && bus.narrow_out_ready;
    assign narrow_in_fire  = bus.narrow_in_valid  && bus.narrow_in_ready;
    assign host_out_fire   = bus.host_out_valid   && bus.host_out_ready;

    always_comb begin
        tx_busy_d = tx_busy_q;
        tx_buf_d  = tx_buf_q;
        tx_idx_d  = tx_idx_q;
        if (narrow_out_fire) begin
            if (tx_last) begin
                tx_busy_d = 1'b0;
            end else begin
                tx_idx_d = tx_idx_q + IDX_W'(1);
            end
        end
        // A new word overrides the end-of-word idle transition.
        if (host_in_fire) begin
            tx_buf_d  = bus.host_in_bits;
            tx_idx_d  = '0;
            tx_busy_d = 1'b1;
        end
    end

    always_comb begin
        rx_full_d = rx_full_q;
        rx_buf_d  = rx_buf_q;
        rx_idx_d  = rx_idx_q;
        if (host_out_fire) begin
            rx_full_d = 1'b0;
        end
        // Completing a word in the drain cycle keeps the buffer full.
        if (narrow_in_fire) begin
            rx_buf_d[int'(rx_idx_q) * NARROW_W +: NARROW_W] = bus.narrow_in_bits;
            if (rx_last) begin
                rx_full_d = 1'b1;
                rx_idx_d  = '0;
            end else begin
                rx_idx_d  = rx_idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_busy_q <= 1'b0;
            tx_buf_q  <= '0;
            tx_idx_q  <= '0;
            rx_full_q <= 1'b0;
            rx_buf_q  <= '0;
            rx_idx_q  <= '0;
        end else begin
            tx_busy_q <= tx_busy_d;
            tx_buf_q  <= tx_buf_d;
            tx_idx_q  <= tx_idx_d;
            rx_full_q <= rx_full_d;
            rx_buf_q  <= rx_buf_d;
            rx_idx_q  <= rx_idx_d;
        end
    end

`ifdef SERIAL_WIDTH_ADAPTER_STATS_EN
    logic [31:0] tx_words_q, rx_words_q;

    // Counters wrap naturally at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_words_q <= '0;
            rx_words_q <= '0;
        end else begin
            if (narrow_out_fire && tx_last) begin
                tx_words_q <= tx_words_q + 32'd1;
            end
            if (host_out_fire) begin
                rx_words_q <= rx_words_q + 32'd1;
            end
        end
    end

    assign tx_words = tx_words_q;
    assign rx_words = rx_words_q;
`endif
endmodule

// File: tb/tb_serial_width_adapter.sv
// Purpose: self-checking bench for serial_width_adapter (directed + random streams).
// Latency: checks first-beat and reassembly timing cycle by cycle.
// Backpressure: random valid/ready stalls on all four stream ends.
module tb_serial_width_adapter;
    localparam int WIDE_W   = 32;
    localparam int NARROW_W = 4;
    localparam int RATIO    = WIDE_W / NARROW_W;
    localparam int N_WORDS  = 1000;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    serial_width_adapter_if #(.WIDE_W(WIDE_W), .NARROW_W(NARROW_W)) bus ();

`ifdef SERIAL_WIDTH_ADAPTER_STATS_EN
    logic [31:0] tx_words, rx_words;
`endif

    serial_width_adapter #(.WIDE_W(WIDE_W), .NARROW_W(NARROW_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus.slave)
`ifdef SERIAL_WIDTH_ADAPTER_STATS_EN
        ,
        .tx_words (tx_words),
        .rx_words (rx_words)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs and outputs are both handled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [NARROW_W-1:0] slice(input logic [WIDE_W-1:0] w, input int k);
        return NARROW_W'(w >> (k * NARROW_W));
    endfunction

    task automatic idle_inputs();
        bus.host_in_valid    = 1'b0;
        bus.host_in_bits     = '0;
        bus.narrow_out_ready = 1'b0;
        bus.narrow_in_valid  = 1'b0;
        bus.narrow_in_bits   = '0;
        bus.host_out_ready   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    // Send one word with the target always ready; expect RATIO beats, LSB first.
    task automatic tx_word(input logic [WIDE_W-1:0] w);
        bus.host_in_valid    = 1'b1;
        bus.host_in_bits     = w;
        bus.narrow_out_ready = 1'b1;
        #1;
        check("tx_accept_ready", 64'(bus.host_in_ready), 64'd1);
        step();
        bus.host_in_valid = 1'b0;
        for (int k = 0; k < RATIO; k++) begin
            check("tx_beat_valid", 64'(bus.narrow_out_valid), 64'd1);
            check("tx_beat_bits", 64'(bus.narrow_out_bits), 64'(slice(w, k)));
            step();
        end
        check("tx_idle_after_word", 64'(bus.narrow_out_valid), 64'd0);
        bus.narrow_out_ready = 1'b0;
    endtask

    // Feed the slices of w as beats, hold the word for 'hold' cycles, then drain.
    task automatic rx_word(input logic [WIDE_W-1:0] w, input int hold);
        bus.host_out_ready = 1'b0;
        for (int k = 0; k < RATIO; k++) begin
            check("rx_not_early", 64'(bus.host_out_valid), 64'd0);
            bus.narrow_in_valid = 1'b1;
            bus.narrow_in_bits  = slice(w, k);
            step();
        end
        check("rx_word_valid", 64'(bus.host_out_valid), 64'd1);
        check("rx_word_bits", 64'(bus.host_out_bits), 64'(w));
        for (int h = 0; h < hold; h++) begin
            bus.narrow_in_bits = NARROW_W'($urandom);
            #1;
            check("rx_hold_in_ready", 64'(bus.narrow_in_ready), 64'd0);
            step();
            check("rx_hold_valid", 64'(bus.host_out_valid), 64'd1);
            check("rx_hold_bits", 64'(bus.host_out_bits), 64'(w));
        end
        bus.narrow_in_valid = 1'b0;
        bus.host_out_ready  = 1'b1;
        #1;
        check("rx_drain_in_ready", 64'(bus.narrow_in_ready), 64'd1);
        step();
        check("rx_drained", 64'(bus.host_out_valid), 64'd0);
        bus.host_out_ready = 1'b0;
    endtask

    logic [NARROW_W-1:0] exp_beats[$];
    logic [WIDE_W-1:0]   exp_words[$];
    logic [NARROW_W-1:0] rx_acc[$];

    initial begin
        logic [WIDE_W-1:0] wa, wb, tx_cur, built;
        int tx_sent, tx_beats_out, rx_beats_in, rx_done;
        logic hf, nf, bf, of;

        // Reset state: readies low while reset is high even with sinks ready.
        idle_inputs();
        bus.narrow_out_ready = 1'b1;
        bus.host_out_ready   = 1'b1;
        step();
        step();
        check("rst_host_in_ready", 64'(bus.host_in_ready), 64'd0);
        check("rst_narrow_in_ready", 64'(bus.narrow_in_ready), 64'd0);
        check("rst_narrow_out_valid", 64'(bus.narrow_out_valid), 64'd0);
        check("rst_host_out_valid", 64'(bus.host_out_valid), 64'd0);
        check("rst_narrow_out_bits", 64'(bus.narrow_out_bits), 64'd0);
        check("rst_host_out_bits", 64'(bus.host_out_bits), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_host_in_ready", 64'(bus.host_in_ready), 64'd1);
        check("post_rst_narrow_in_ready", 64'(bus.narrow_in_ready), 64'd1);
        idle_inputs();

        // Serialize a single word.
        tx_word(32'h89ABCDEF);

        // Back-to-back words: 16 beats without a bubble.
        wa = 32'h12345678;
        wb = 32'hCAFEF00D;
        bus.narrow_out_ready = 1'b1;
        bus.host_in_valid    = 1'b1;
        bus.host_in_bits     = wa;
        step();
        bus.host_in_bits = wb;
        for (int k = 0; k < 2 * RATIO; k++) begin
            #1;
            check("b2b_valid", 64'(bus.narrow_out_valid), 64'd1);
            check("b2b_bits", 64'(bus.narrow_out_bits),
                  64'((k < RATIO) ? slice(wa, k) : slice(wb, k - RATIO)));
            if (k == RATIO - 1) begin
                check("b2b_ready_on_last", 64'(bus.host_in_ready), 64'd1);
            end
            step();
            if (k == RATIO - 1) begin
                bus.host_in_valid = 1'b0;
            end
        end
        check("b2b_idle", 64'(bus.narrow_out_valid), 64'd0);
        idle_inputs();

        // Deserialize beats 1..8 and hold the word under backpressure.
        rx_word(32'h87654321, 5);

        // Reset mid-word in both directions.
        bus.host_in_valid    = 1'b1;
        bus.host_in_bits     = 32'h13572468;
        bus.narrow_out_ready = 1'b0;
        bus.narrow_in_valid  = 1'b1;
        bus.narrow_in_bits   = 4'h3;
        step();
        bus.host_in_valid    = 1'b0;
        bus.narrow_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) step();
        bus.narrow_out_ready = 1'b0;
        step();
        check("mid_tx_busy", 64'(bus.narrow_out_valid), 64'd1);
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_tx_valid", 64'(bus.narrow_out_valid), 64'd0);
        check("mid_rst_rx_valid", 64'(bus.host_out_valid), 64'd0);
        tx_word(32'hA5C3_1E7F);
        rx_word(32'h0F1E_2D3C, 0);

`ifdef SERIAL_WIDTH_ADAPTER_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tx_word($urandom);
            rx_word($urandom, 0);
        end
        check("stats_tx_words", 64'(tx_words), 64'd3);
        check("stats_rx_words", 64'(rx_words), 64'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("stats_tx_rst", 64'(tx_words), 64'd0);
        check("stats_rx_rst", 64'(rx_words), 64'd0);
`endif

        // Random stalls on every end; reference model is a beat queue per direction.
        do_reset();
        tx_sent      = 0;
        tx_beats_out = 0;
        rx_beats_in  = 0;
        rx_done      = 0;
        tx_cur       = $urandom;
        for (int cyc = 0; cyc < 40000 &&
             (tx_beats_out < N_WORDS * RATIO || rx_done < N_WORDS); cyc++) begin
            bus.host_in_valid    = (tx_sent < N_WORDS) && ($urandom_range(0, 3) != 0);
            bus.host_in_bits     = tx_cur;
            bus.narrow_out_ready = ($urandom_range(0, 3) != 0);
            bus.narrow_in_valid  = (rx_beats_in < N_WORDS * RATIO) && ($urandom_range(0, 3) != 0);
            bus.narrow_in_bits   = NARROW_W'($urandom);
            bus.host_out_ready   = ($urandom_range(0, 3) != 0);
            #1;
            hf = bus.host_in_valid   && bus.host_in_ready;
            nf = bus.narrow_out_valid && bus.narrow_out_ready;
            bf = bus.narrow_in_valid  && bus.narrow_in_ready;
            of = bus.host_out_valid   && bus.host_out_ready;
            if (nf) begin
                tx_beats_out++;
                if (exp_beats.size() == 0) begin
                    check("rand_tx_extra_beat", 64'd1, 64'd0);
                end else begin
                    check("rand_tx_beat", 64'(bus.narrow_out_bits), 64'(exp_beats.pop_front()));
                end
            end
            if (hf) begin
                for (int k = 0; k < RATIO; k++) exp_beats.push_back(slice(tx_cur, k));
                tx_sent++;
                tx_cur = $urandom;
            end
            if (of) begin
                rx_done++;
                if (exp_words.size() == 0) begin
                    check("rand_rx_extra_word", 64'd1, 64'd0);
                end else begin
                    check("rand_rx_word", 64'(bus.host_out_bits), 64'(exp_words.pop_front()));
                end
            end
            if (bf) begin
                rx_beats_in++;
                rx_acc.push_back(bus.narrow_in_bits);
                if (rx_acc.size() == RATIO) begin
                    built = '0;
                    for (int k = 0; k < RATIO; k++) built = built | (WIDE_W'(rx_acc[k]) << (k * NARROW_W));
                    exp_words.push_back(built);
                    rx_acc.delete();
                end
            end
            step();
        end
        check("rand_tx_words_sent", 64'(tx_sent), 64'(N_WORDS));
        check("rand_tx_beats_out", 64'(tx_beats_out), 64'(N_WORDS * RATIO));
        check("rand_rx_words_out", 64'(rx_done), 64'(N_WORDS));
        check("rand_tx_queue_empty", 64'(exp_beats.size()), 64'd0);
        check("rand_rx_queue_empty", 64'(exp_words.size()), 64'd0);
        idle_inputs();
        step();
        check("rand_end_tx_idle", 64'(bus.narrow_out_valid), 64'd0);
        check("rand_end_rx_idle", 64'(bus.host_out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/serial_width_adapter.md
# serial_width_adapter

Bidirectional width converter between the 32-bit host serial port on the simulation tether and a narrow serial link into the target. Host-to-target words are split into NARROW_W-bit beats, LSB slice first. Target-to-host beats are reassembled into full words. Each direction is an independent valid/ready stream with one-word buffering and full throughput of one beat per cycle.

## Interface
- WIDE_W, 32, host-side word width; must be an integer multiple of NARROW_W.
- NARROW_W, 4, target-side beat width; RATIO = WIDE_W/NARROW_W, must be at least 2.
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- host_in_valid  in  1  host word available (host→target).
- host_in_ready  out  1  adapter accepts host word.
- host_in_bits  in  WIDE_W  host word.
- narrow_out_valid  out  1  beat to target valid.
- narrow_out_ready  in  1  target accepts beat.
- narrow_out_bits  out  NARROW_W  beat to target.
- narrow_in_valid  in  1  beat from target valid.
- narrow_in_ready  out  1  adapter accepts target beat.
- narrow_in_bits  in  NARROW_W  beat from target.
- host_out_valid  out  1  reassembled word valid (target→host).
- host_out_ready  in  1  host accepts word.
- host_out_bits  out  WIDE_W  reassembled word.

## Operation
Serializer (host→target):
- State: tx_busy, tx_buf[WIDE_W], tx_idx in 0..RATIO-1.
- host_in_ready = !reset && (!tx_busy || (tx_idx==RATIO-1 && narrow_out_ready)).
- Host fire: tx_buf<=host_in_bits, tx_idx<=0, tx_busy<=1.
- narrow_out_valid = tx_busy; narrow_out_bits = tx_buf[tx_idx*NARROW_W +: NARROW_W].
- Narrow fire with tx_idx<RATIO-1: tx_idx+1.
- Narrow fire on the last beat: tx_busy<=0, unless a host fire occurs in the same cycle. In that case the new word loads and tx_idx<=0, giving a gapless stream.

Deserializer (target→host):
- State: rx_full, rx_buf[WIDE_W], rx_idx in 0..RATIO-1.
- narrow_in_ready = !reset && (!rx_full || host_out_ready).
- Beat fire: rx_buf[rx_idx*NARROW_W +: NARROW_W]<=narrow_in_bits. If rx_idx==RATIO-1: rx_full<=1, rx_idx<=0. Otherwise rx_idx+1.
- host_out_valid = rx_full; host_out_bits = rx_buf.
- Host fire clears rx_full, unless the same cycle completes a new word, in which case rx_full stays 1.
- A beat arriving while the old word drains writes a slice of rx_buf. This is legal only because the drain completes in that same cycle. Bits not yet rewritten are stale but not visible until rx_full.
- Stale bits are not cleared between words.

General:
- The two directions share no state.
- Valid must not depend combinationally on ready. Bits are stable while valid && !ready.
- Inputs with valid low are ignored.

## Timing
- Reset values: tx_busy=0, rx_full=0, tx_idx=rx_idx=0, tx_buf=rx_buf=0.
- Output reset values: narrow_out_valid=0, host_out_valid=0, narrow_out_bits=0, host_out_bits=0, host_in_ready=0 and narrow_in_ready=0 while reset is high, both readies 1 in the first cycle after reset.
- Serializer latency: host fire in cycle t gives the first beat valid in t+1. With ready held high, the last beat is in t+RATIO, and the next word is accepted in t+RATIO.
- Deserializer latency: last beat fire in cycle t gives host_out_valid in t+1.
- Sustained rate: one beat per cycle in each direction.
- Reset mid-word: a partial word in either direction is discarded, with no partial output.
- Backpressure: narrow_out_ready low freezes tx_idx. host_out_ready low with rx_full deasserts narrow_in_ready.

## Configuration
- SERIAL_WIDTH_ADAPTER_STATS_EN defined: adds outputs tx_words (out, 32) and rx_words (out, 32).
- tx_words counts last-beat narrow_out fires; rx_words counts host_out fires.
- Both counters reset to 0 and wrap modulo 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Serialize: WIDE_W=32, NARROW_W=4, host word 0x89ABCDEF, ready held high -> beats F,E,D,C,B,A,9,8 in cycles t+1..t+8.
- Back-to-back: words 0x12345678 then 0xCAFEF00D -> 16 consecutive beats, no bubble, host_in_ready high on beat 8.
- Deserialize: beats 1,2,...,8 -> host_out_bits=0x87654321 one cycle after the 8th beat. Hold host_out_ready low 5 cycles -> narrow_in_ready low and word stable.
- Random valid/ready stalls on both sides, 1000 words each direction -> scoreboard exact match, no loss or duplication.
- Reset after 3 of 8 serializer beats and 5 of 8 deserializer beats -> both valids 0 next cycle. A new word afterwards starts at slice 0.
- STATS_EN: send 3 words each way -> tx_words=3, rx_words=3. Reset -> both 0.
